// File: rtl/encoder_round_scheduler_if.sv
// Handshake bundle between the round scheduler and its controller/stage side.
// The controller drives start/abort and collects stage ready pulses; the scheduler drives the rest.
interface encoder_round_scheduler_if #(
  parameter int NUM_STAGES = 5,
  parameter int RW         = 5
);
  logic                  start;
  logic                  abort;
  logic [NUM_STAGES-1:0] stage_ready;
  logic [NUM_STAGES-1:0] stage_start;
  logic [2:0]            stage_idx;
  logic [RW-1:0]         round_idx;
  logic                  buf_sel;
  logic                  busy;
  logic                  ready;

  modport master (
    output start, abort, stage_ready,
    input  stage_start, stage_idx, round_idx, buf_sel, busy, ready
  );

  modport slave (
    input  start, abort, stage_ready,
    output stage_start, stage_idx, round_idx, buf_sel, busy, ready
  );
endinterface

// File: rtl/encoder_round_scheduler.sv
// Sequences the round stage controllers NUM_ROUNDS times in fixed order,
// toggling the ping-pong buffer select after every stage.
module encoder_round_scheduler #(
  parameter int NUM_STAGES = 5,
  parameter int NUM_ROUNDS = 24,
  parameter int RW         = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  encoder_round_scheduler_if.slave    bus
);

  localparam logic [2:0] IDLING  = 3'd0;
  localparam logic [2:0] ARMING  = 3'd1;
  localparam logic [2:0] ISSUE   = 3'd2;
  localparam logic [2:0] WAITING = 3'd3;
  localparam logic [2:0] ADVANCE = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  logic [2:0]            state_reg;
  logic [2:0]            state_next;
  logic [2:0]            stage_idx_reg;
  logic [RW-1:0]         round_idx_reg;
  logic                  buf_sel_reg;
  logic [NUM_STAGES-1:0] stage_onehot;
  logic                  ready_hit;
  logic                  last_stage;
  logic                  last_round;

  // One-hot decode of the active stage, reused for both start steering and ready selection.
  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_onehot
      assign stage_onehot[gi] = (stage_idx_reg == 3'(gi));
    end
  endgenerate

  assign ready_hit  = |(bus.stage_ready & stage_onehot);
  assign last_stage = (stage_idx_reg == 3'(NUM_STAGES - 1));
  assign last_round = (round_idx_reg == RW'(NUM_ROUNDS - 1));

  always_comb begin
    state_next = state_reg;
    if (bus.abort) begin
      state_next = IDLING;
    end else begin
      case (state_reg)
        IDLING:  if (bus.start) state_next = ARMING;
        ARMING:  if (!bus.start) state_next = ISSUE;
        ISSUE:   state_next = WAITING;
        WAITING: if (ready_hit) state_next = ADVANCE;
        ADVANCE: state_next = (last_stage && last_round) ? DONE : ISSUE;
        DONE:    state_next = IDLING;
        default: state_next = IDLING;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLING;
    end else begin
      state_reg <= state_next;
    end
  end

  // Counters freeze on abort so the aborted position stays observable until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_idx_reg <= 3'd0;
      round_idx_reg <= '0;
      buf_sel_reg   <= 1'b0;
    end else if (!bus.abort) begin
      if (state_reg == IDLING && bus.start) begin
        stage_idx_reg <= 3'd0;
        round_idx_reg <= '0;
        buf_sel_reg   <= 1'b0;
      end else if (state_reg == ADVANCE) begin
        buf_sel_reg <= ~buf_sel_reg;
        if (last_stage) begin
          stage_idx_reg <= 3'd0;
          if (!last_round) begin
            round_idx_reg <= round_idx_reg + RW'(1);
          end
        end else begin
          stage_idx_reg <= stage_idx_reg + 3'd1;
        end
      end
    end
  end

  assign bus.stage_start = (state_reg == ISSUE) ? stage_onehot : '0;
  assign bus.stage_idx   = stage_idx_reg;
  assign bus.round_idx   = round_idx_reg;
  assign bus.buf_sel     = buf_sel_reg;
  assign bus.busy        = (state_reg != IDLING);
  assign bus.ready       = (state_reg == DONE);

endmodule

// File: tb/tb_encoder_round_scheduler.sv
// Scoreboard bench for the round scheduler: stimulus queues expected stage_start/ready
// events, a negedge monitor pops and compares them as the scheduler emits them.
module tb_encoder_round_scheduler;

  localparam int NS = 5;
  localparam int NR = 24;
  localparam int RW = 5;

  typedef struct {
    bit         is_ready;
    logic [4:0] start_vec;
    logic [2:0] sidx;
    logic [4:0] ridx;
    logic       bsel;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stub_en = 1'b0;
  logic [4:0] man_ready = '0;
  logic [4:0] d1 = '0, d2 = '0, d3 = '0;
  bit   op_arm = 1'b0;
  int   op_cycle = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  encoder_round_scheduler_if #(.NUM_STAGES(NS), .RW(RW)) bus ();

  encoder_round_scheduler #(.NUM_STAGES(NS), .NUM_ROUNDS(NR), .RW(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Stub stages: ready arrives three cycles after the start pulse.
  always @(posedge clk) begin
    d1 <= bus.stage_start;
    d2 <= d1;
    d3 <= d2;
  end
  assign bus.stage_ready = (stub_en ? d3 : 5'b0) | man_ready;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (op_arm && bus.stage_start != 0) begin
        op_cycle = 1;
        op_arm   = 1'b0;
      end else begin
        op_cycle++;
      end
      if (bus.stage_start != 0 || bus.ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", {bus.ready, bus.stage_start}, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("event_kind", bus.ready, e.is_ready);
          if (e.is_ready) begin
            check("ready_cycle", op_cycle, e.cyc);
            check("final_buf_sel", bus.buf_sel, e.bsel);
            $display("ready at cycle %0d buf_sel=%0d", op_cycle, bus.buf_sel);
          end else begin
            check("stage_start", bus.stage_start, e.start_vec);
            check("stage_idx", bus.stage_idx, e.sidx);
            check("round_idx", bus.round_idx, e.ridx);
            check("buf_sel", bus.buf_sel, e.bsel);
            $display("issue stage=%0d round=%0d buf_sel=%0d", bus.stage_idx, bus.round_idx, bus.buf_sel);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stage number n counts issues from 0; buffer toggles once per stage.
  function automatic void push_start(input int n);
    exp_t e;
    logic [4:0] one;
    one         = 5'b00001;
    e.is_ready  = 1'b0;
    e.start_vec = one << (n % NS);
    e.sidx      = 3'(n % NS);
    e.ridx      = 5'(n / NS);
    e.bsel      = 1'(n % 2);
    e.cyc       = 0;
    sb.push_back(e);
  endfunction

  function automatic void push_ready();
    exp_t e;
    e.is_ready  = 1'b1;
    e.start_vec = '0;
    e.sidx      = '0;
    e.ridx      = '0;
    e.bsel      = 1'b0;
    e.cyc       = 601;
    sb.push_back(e);
  endfunction

  task automatic launch(input int hold);
    bus.start = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("no_start_while_armed", bus.stage_start, 0);
    end
    bus.start = 1'b0;
    op_arm    = 1'b1;
  endtask

  task automatic wait_drain(input int bound, input string name);
    int i;
    for (i = 0; i < bound; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    if (i == bound) begin
      check(name, sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic wait_issue();
    int i;
    for (i = 0; i < 20; i++) begin
      if (bus.stage_start != 0) break;
      tick();
    end
    if (i == 20) check("issue_timeout", 0, 1);
  endtask

  task automatic run_full(input int hold, input bit poke);
    stub_en = 1'b1;
    for (int n = 0; n < NS * NR; n++) push_start(n);
    push_ready();
    launch(hold);
    if (poke) begin
      tick(); tick(); tick();
      bus.start = 1'b1;
      tick(); tick();
      bus.start = 1'b0;
    end
    wait_drain(1000, "full_run_timeout");
    tick();
    check("post_round_idx", bus.round_idx, NR - 1);
    check("post_buf_sel", bus.buf_sel, 0);
    check("post_busy", bus.busy, 0);
    stub_en = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_busy", bus.busy, 0);
    check("rst_stage_start", bus.stage_start, 0);
    check("rst_stage_idx", bus.stage_idx, 0);
    check("rst_round_idx", bus.round_idx, 0);
    check("rst_buf_sel", bus.buf_sel, 0);
    check("rst_ready", bus.ready, 0);

    // Full run with a 2-cycle start pulse
    run_full(2, 1'b0);
    // Long start hold, then start re-asserted mid-operation
    run_full(10, 1'b1);

    // Manually served stages: spurious ready at stage 0, abort at round 3 stage 2
    launch(1);
    for (int n = 0; n <= 17; n++) begin
      push_start(n);
      wait_issue();
      tick();
      if (n == 0) begin
        man_ready = 5'b00100;
        tick();
        man_ready = '0;
        tick(); tick();
        check("spurious_stage_idx", bus.stage_idx, 0);
        check("spurious_busy", bus.busy, 1);
        check("spurious_no_start", bus.stage_start, 0);
      end
      if (n == 17) begin
        man_ready = 5'b00100;
        bus.abort = 1'b1;
        tick();
        man_ready = '0;
        bus.abort = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_ready", bus.ready, 0);
        check("abort_round_held", bus.round_idx, 3);
        check("abort_stage_held", bus.stage_idx, 2);
      end else begin
        man_ready = 5'b00001 << (n % NS);
        tick();
        man_ready = '0;
      end
    end
    for (int i = 0; i < 10; i++) tick();
    wait_drain(5, "abort_leftover");
    run_full(1, 1'b0);

    // Asynchronous reset in the middle of round 7
    stub_en = 1'b1;
    for (int n = 0; n <= 35; n++) push_start(n);
    launch(1);
    wait_drain(400, "reset_run_timeout");
    tick();
    check("pre_rst_round", bus.round_idx, 7);
    rst = 1'b1;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_stage_start", bus.stage_start, 0);
    check("midrst_round_idx", bus.round_idx, 0);
    check("midrst_buf_sel", bus.buf_sel, 0);
    check("midrst_ready", bus.ready, 0);
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("after_rst_busy", bus.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
